game_flow_ctrl: RTL and testbench
=================================

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_STAGES, 3, playable stages (1..9).
- NUM_KEYS, 3, keys to collect before the door opens.
- POS_W, 9, coordinate width.
- MAP_W, 320, map width in pixels.
- MAP_H, 240, map height in pixels.
- SPR, 16, player/object/boss square size.
- STEP, 4, pixels moved per key press.
- SPAWN_X, 8, player start x.
- SPAWN_Y, 8, player start y.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, reset.
- key_valid, in, 1, one-cycle pulse for a new key press.
- key_code, in, 4, decoded key: 1..9 stage digit, 4 W, 5 A, 6 S, 7 D, 8 n, 9 b, 10 r, 15 none.
- obj_x / obj_y, in, POS_W each, current target (key or door) position.
- boss_x / boss_y, in, POS_W each, boss position.
- state, out, 3, TITLE=0, PLAY=1, SUCCESS=2, FAIL=3, STAFF=4.
- stage, out, 4, current stage index (0-based).
- player_x / player_y, out, POS_W each, player position.
- key_find, out, $clog2(NUM_KEYS+1), keys collected.
- play_valid, out, NUM_STAGES, unlocked stages.
- obj_taken, out, 1, one-cycle pulse: key collected, next object requested.
- todo, out, 2, NONE=0, FIND_KEY=1, FIND_DOOR=3.

REQ-003 Reset SHALL be rst, asynchronous, active-high; clock SHALL be clk.

REQ-004 Digits 1..9 SHALL select stage digit-1, valid only when digit ≤ NUM_STAGES.

Function
REQ-005 key_code SHALL be acted on only in a cycle with key_valid=1; all registers SHALL update on the rising edge of clk.

REQ-006 TITLE: a digit d with play_valid[d-1]=1 SHALL move to PLAY next cycle with stage=d-1, player at (SPAWN_X, SPAWN_Y) and key_find=0; any other key SHALL be ignored.

REQ-007 PLAY movement on W/A/S/D, one STEP per press, saturating:
- W: y=max(y-STEP, 0); S: y=min(y+STEP, MAP_H-SPR).
- A: x=max(x-STEP, 0); D: x=min(x+STEP, MAP_W-SPR).
- The position SHALL never wrap.
- Movement outside PLAY SHALL be ignored.

REQ-008 Overlap SHALL be true when |player_x-tx| < SPR and |player_y-ty| < SPR. It SHALL be evaluated every PLAY cycle on current register values, unsigned and width-safe.

REQ-009 Object overlap with key_find < NUM_KEYS SHALL:
- increment key_find;
- pulse obj_taken for exactly 1 cycle;
- block further object hits for the following 2 cycles (holdoff while the object relocates).

REQ-010 Object overlap with key_find == NUM_KEYS (door) SHALL move to SUCCESS and set play_valid[stage+1] when stage+1 < NUM_STAGES; play_valid bits SHALL never clear except on reset.

REQ-011 Boss overlap SHALL apply only when stage == NUM_STAGES-1 and SHALL move to FAIL. It SHALL take priority over object/door overlap in the same cycle; in that case key_find is unchanged and obj_taken is not pulsed.

REQ-012 A movement key and an overlap in the same cycle: the overlap SHALL be judged on the pre-move position, and the move SHALL still be applied.

REQ-013 SUCCESS key handling:
- n with stage < NUM_STAGES-1 → PLAY with stage+1, spawn position, key_find=0.
- n with the last stage → STAFF.
- b → TITLE.
- Other keys are ignored.

REQ-014 FAIL: r SHALL re-enter PLAY on the same stage with spawn position and key_find=0; b SHALL go to TITLE.

REQ-015 STAFF: only b SHALL go to TITLE.

REQ-016 todo SHALL be registered, one cycle after its inputs:
- FIND_KEY in PLAY with key_find < NUM_KEYS;
- FIND_DOOR in PLAY with key_find == NUM_KEYS;
- NONE otherwise.

Reset
REQ-017 While rst=1 the outputs SHALL be:
- state=TITLE, stage=0;
- player=(SPAWN_X, SPAWN_Y);
- key_find=0, play_valid=1 (stage 0 only);
- obj_taken=0, todo=NONE;
- holdoff counter cleared.

REQ-018 Assertion of rst in any state, including mid-PLAY, SHALL take effect immediately and discard all progress.

Verification
REQ-019 Reset, then key 2 → stays TITLE; key 1 → state=1, stage=0, player=(8,8), todo=1 one cycle later.

REQ-020 In PLAY at (8,8), with the object far away:
- W×3 → y=0, no wrap;
- D×80 → x=304 (MAP_W-SPR).

REQ-021 Place obj_x/obj_y at the player position, then relocate it 2 cycles after each pulse, three times:
- obj_taken pulses 3 times;
- key_find=3 and todo=3;
- a door overlap then gives state=2 and play_valid=3'b011.

REQ-022 Object kept overlapping without relocation → exactly one increment per 3-cycle window, never beyond NUM_KEYS.

REQ-023 Stage 2 (index), boss and door overlapping in the same cycle → state=FAIL, key_find unchanged; r → PLAY, stage=2, key_find=0; b from FAIL → TITLE.

REQ-024 Final SUCCESS + n → STAFF; b → TITLE; rst mid-PLAY → all REQ-017 values next observation.

Source files
------------

// File: rtl/game_flow_if.sv
// Bundle of game control signals between the key/object front end and the flow controller.
// The master side supplies key presses and object positions; the slave side reports game state.
interface game_flow_if #(
  parameter int NUM_STAGES = 3,
  parameter int NUM_KEYS   = 3,
  parameter int POS_W      = 9
);
  logic                             key_valid;
  logic [3:0]                       key_code;
  logic [POS_W-1:0]                 obj_x;
  logic [POS_W-1:0]                 obj_y;
  logic [POS_W-1:0]                 boss_x;
  logic [POS_W-1:0]                 boss_y;
  logic [2:0]                       state;
  logic [3:0]                       stage;
  logic [POS_W-1:0]                 player_x;
  logic [POS_W-1:0]                 player_y;
  logic [$clog2(NUM_KEYS+1)-1:0]    key_find;
  logic [NUM_STAGES-1:0]            play_valid;
  logic                             obj_taken;
  logic [1:0]                       todo;

  modport master (
    output key_valid, key_code, obj_x, obj_y, boss_x, boss_y,
    input  state, stage, player_x, player_y, key_find, play_valid, obj_taken, todo
  );

  modport slave (
    input  key_valid, key_code, obj_x, obj_y, boss_x, boss_y,
    output state, stage, player_x, player_y, key_find, play_valid, obj_taken, todo
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game flow controller: title/play/success/fail/staff screens, player movement,
// key collection with relocation holdoff, door and boss collision handling.
module game_flow_ctrl #(
  parameter int NUM_STAGES = 3,
  parameter int NUM_KEYS   = 3,
  parameter int POS_W      = 9,
  parameter int MAP_W      = 320,
  parameter int MAP_H      = 240,
  parameter int SPR        = 16,
  parameter int STEP       = 4,
  parameter int SPAWN_X    = 8,
  parameter int SPAWN_Y    = 8
) (
  input  logic         clk,
  input  logic         rst,
  game_flow_if.slave   bus
);
  localparam int KF_W = $clog2(NUM_KEYS+1);
  localparam int CW   = POS_W + 1;

  localparam logic [CW-1:0]    X_MAX    = CW'(MAP_W - SPR);
  localparam logic [CW-1:0]    Y_MAX    = CW'(MAP_H - SPR);
  localparam logic [CW-1:0]    STEP_C   = CW'(STEP);
  localparam logic [CW-1:0]    SPR_C    = CW'(SPR);
  localparam logic [POS_W-1:0] SPN_X    = POS_W'(SPAWN_X);
  localparam logic [POS_W-1:0] SPN_Y    = POS_W'(SPAWN_Y);
  localparam logic [KF_W-1:0]  KF_MAX   = KF_W'(NUM_KEYS);
  localparam logic [3:0]       LAST_STG = 4'(NUM_STAGES - 1);

  localparam logic [3:0] K_W = 4'd4, K_A = 4'd5, K_S = 4'd6, K_D = 4'd7;
  localparam logic [3:0] K_N = 4'd8, K_B = 4'd9, K_R = 4'd10;

  localparam logic [1:0] TODO_NONE = 2'd0, TODO_KEY = 2'd1, TODO_DOOR = 2'd3;

  typedef enum logic [2:0] {
    S_TITLE   = 3'd0,
    S_PLAY    = 3'd1,
    S_SUCCESS = 3'd2,
    S_FAIL    = 3'd3,
    S_STAFF   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            stage_q, stage_d;
  logic [POS_W-1:0]      px_q, px_d, py_q, py_d;
  logic [KF_W-1:0]       kf_q, kf_d;
  logic [NUM_STAGES-1:0] pv_q, pv_d;
  logic                  obj_taken_q, obj_taken_d;
  logic [1:0]            todo_q, todo_d;
  logic [1:0]            hold_q, hold_d;

  // Unsigned distance test on one axis, safe against underflow.
  function automatic logic axis_near(input logic [POS_W-1:0] a, input logic [POS_W-1:0] b);
    logic [POS_W-1:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return ({1'b0, d} < SPR_C);
  endfunction

  logic          obj_hit, boss_hit, sel_ok;
  logic [3:0]    sel_idx;
  logic [CW-1:0] px_e, py_e;

  assign px_e     = {1'b0, px_q};
  assign py_e     = {1'b0, py_q};
  assign obj_hit  = axis_near(px_q, bus.obj_x)  && axis_near(py_q, bus.obj_y);
  assign boss_hit = axis_near(px_q, bus.boss_x) && axis_near(py_q, bus.boss_y) &&
                    (stage_q == LAST_STG);

  always_comb begin
    sel_ok  = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (bus.key_code == 4'(i + 1) && pv_q[i]) begin
        sel_ok  = 1'b1;
        sel_idx = 4'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    px_d        = px_q;
    py_d        = py_q;
    kf_d        = kf_q;
    pv_d        = pv_q;
    obj_taken_d = 1'b0;
    hold_d      = hold_q;
    todo_d      = TODO_NONE;

    if (state_q == S_PLAY) todo_d = (kf_q == KF_MAX) ? TODO_DOOR : TODO_KEY;

    case (state_q)
      S_TITLE: begin
        if (bus.key_valid && sel_ok) begin
          state_d = S_PLAY;
          stage_d = sel_idx;
          px_d    = SPN_X;
          py_d    = SPN_Y;
          kf_d    = '0;
          hold_d  = '0;
        end
      end
      S_PLAY: begin
        if (hold_q != 2'd0) hold_d = hold_q - 2'd1;
        // Collisions use the pre-move position; a move in the same cycle still applies.
        if (boss_hit) begin
          state_d = S_FAIL;
        end else if (obj_hit && hold_q == 2'd0) begin
          if (kf_q < KF_MAX) begin
            kf_d        = kf_q + KF_W'(1);
            obj_taken_d = 1'b1;
            hold_d      = 2'd2;
          end else begin
            state_d = S_SUCCESS;
            for (int i = 1; i < NUM_STAGES; i++)
              if (stage_q == 4'(i - 1)) pv_d[i] = 1'b1;
          end
        end
        if (bus.key_valid) begin
          case (bus.key_code)
            K_W: py_d = (py_e < STEP_C) ? '0 : POS_W'(py_e - STEP_C);
            K_S: py_d = (py_e + STEP_C > Y_MAX) ? POS_W'(Y_MAX) : POS_W'(py_e + STEP_C);
            K_A: px_d = (px_e < STEP_C) ? '0 : POS_W'(px_e - STEP_C);
            K_D: px_d = (px_e + STEP_C > X_MAX) ? POS_W'(X_MAX) : POS_W'(px_e + STEP_C);
            default: ;
          endcase
        end
      end
      S_SUCCESS: begin
        if (bus.key_valid && bus.key_code == K_N) begin
          if (stage_q < LAST_STG) begin
            state_d = S_PLAY;
            stage_d = stage_q + 4'd1;
            px_d    = SPN_X;
            py_d    = SPN_Y;
            kf_d    = '0;
            hold_d  = '0;
          end else begin
            state_d = S_STAFF;
          end
        end else if (bus.key_valid && bus.key_code == K_B) begin
          state_d = S_TITLE;
        end
      end
      S_FAIL: begin
        if (bus.key_valid && bus.key_code == K_R) begin
          state_d = S_PLAY;
          px_d    = SPN_X;
          py_d    = SPN_Y;
          kf_d    = '0;
          hold_d  = '0;
        end else if (bus.key_valid && bus.key_code == K_B) begin
          state_d = S_TITLE;
        end
      end
      S_STAFF: begin
        if (bus.key_valid && bus.key_code == K_B) state_d = S_TITLE;
      end
      default: state_d = S_TITLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_TITLE;
      stage_q     <= '0;
      px_q        <= SPN_X;
      py_q        <= SPN_Y;
      kf_q        <= '0;
      pv_q        <= NUM_STAGES'(1);
      obj_taken_q <= 1'b0;
      todo_q      <= TODO_NONE;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      px_q        <= px_d;
      py_q        <= py_d;
      kf_q        <= kf_d;
      pv_q        <= pv_d;
      obj_taken_q <= obj_taken_d;
      todo_q      <= todo_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.stage      = stage_q;
  assign bus.player_x   = px_q;
  assign bus.player_y   = py_q;
  assign bus.key_find   = kf_q;
  assign bus.play_valid = pv_q;
  assign bus.obj_taken  = obj_taken_q;
  assign bus.todo       = todo_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: directed key/object sequences push expected
// snapshots and key-pickup results; a negedge monitor pops and compares them.
module tb_game_flow_ctrl;
  localparam int NS = 3, NK = 3, PW = 9;
  localparam logic [3:0] K_W = 4'd4, K_A = 4'd5, K_S = 4'd6, K_D = 4'd7;
  localparam logic [3:0] K_N = 4'd8, K_B = 4'd9, K_R = 4'd10, K_NONE = 4'd15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_flow_if #(.NUM_STAGES(NS), .NUM_KEYS(NK), .POS_W(PW)) bus ();

  game_flow_ctrl #(.NUM_STAGES(NS), .NUM_KEYS(NK), .POS_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      nm;
    logic [2:0] st;
    logic [3:0] stg;
    logic [8:0] px;
    logic [8:0] py;
    logic [1:0] kf;
    logic [2:0] pv;
    logic [1:0] todo;
  } exp_t;

  exp_t exp_q[$];
  int   tk_q[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  logic chk_stb = 1'b0, done = 1'b0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic press(input logic [3:0] c);
    bus.key_valid = 1'b1; bus.key_code = c;
    step();
    bus.key_valid = 1'b0; bus.key_code = K_NONE;
  endtask

  task automatic press_n(input logic [3:0] c, input int n);
    for (int i = 0; i < n; i++) press(c);
  endtask

  task automatic obj_at(input int x, input int y);
    bus.obj_x = 9'(x); bus.obj_y = 9'(y);
  endtask

  task automatic boss_at(input int x, input int y);
    bus.boss_x = 9'(x); bus.boss_y = 9'(y);
  endtask

  task automatic chk(input string nm, input int st, input int stg, input int px, input int py,
                     input int kf, input logic [2:0] pv, input int todo);
    exp_t e;
    e.nm = nm; e.st = 3'(st); e.stg = 4'(stg); e.px = 9'(px); e.py = 9'(py);
    e.kf = 2'(kf); e.pv = pv; e.todo = 2'(todo);
    exp_q.push_back(e);
    chk_stb = 1'b1;
    step();
    chk_stb = 1'b0;
  endtask

  // Put the object on the player, then move it away two cycles after the pickup pulse.
  task automatic take_key(input int kf, input int x, input int y);
    tk_q.push_back(kf);
    obj_at(x, y);
    step(); step();
    obj_at(150, 150);
    step();
  endtask

  initial begin : monitor
    exp_t e;
    int   k;
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_stb) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard_empty: strobe with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          if (bus.state !== e.st || bus.stage !== e.stg || bus.player_x !== e.px ||
              bus.player_y !== e.py || bus.key_find !== e.kf || bus.play_valid !== e.pv ||
              bus.todo !== e.todo) begin
            n_bad++;
            $display("FAIL %s: got st=%0d stg=%0d pos=(%0d,%0d) kf=%0d pv=%b todo=%0d, want st=%0d stg=%0d pos=(%0d,%0d) kf=%0d pv=%b todo=%0d",
                     e.nm, bus.state, bus.stage, bus.player_x, bus.player_y, bus.key_find,
                     bus.play_valid, bus.todo, e.st, e.stg, e.px, e.py, e.kf, e.pv, e.todo);
          end
        end
      end
      if (bus.obj_taken === 1'b1) begin
        n_cmp++;
        if (tk_q.size() == 0) begin
          n_bad++;
          $display("FAIL obj_taken_unexpected: pulse at cycle %0d with key_find=%0d, want no pulse",
                   cyc, bus.key_find);
        end else begin
          k = tk_q.pop_front();
          if (bus.key_find !== 2'(k)) begin
            n_bad++;
            $display("FAIL obj_taken_count: key_find=%0d at pulse, want %0d", bus.key_find, k);
          end
        end
      end
      if (done || cyc > 20000) begin
        if (!done) begin
          n_cmp++; n_bad++;
          $display("FAIL timeout: stimulus still running at cycle %0d, want completion", cyc);
        end
        n_cmp++;
        if (tk_q.size() != 0 || exp_q.size() != 0) begin
          n_bad++;
          $display("FAIL pending: missing obj_taken pulses=%0d unchecked snapshots=%0d, want 0 and 0",
                   tk_q.size(), exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  initial begin : stim
    rst = 1'b1;
    bus.key_valid = 1'b0; bus.key_code = K_NONE;
    obj_at(150, 150); boss_at(250, 100);
    step(); step();
    chk("reset", 0, 0, 8, 8, 0, 3'b001, 0);
    rst = 1'b0;

    press(4'd2); chk("title_locked", 0, 0, 8, 8, 0, 3'b001, 0);
    press(4'd1); chk("enter_play",   1, 0, 8, 8, 0, 3'b001, 0);
    chk("todo_find_key", 1, 0, 8, 8, 0, 3'b001, 1);

    press_n(K_W, 3);  chk("w_floor",   1, 0, 8,   0,   0, 3'b001, 1);
    press_n(K_D, 80); chk("d_ceiling", 1, 0, 304, 0,   0, 3'b001, 1);
    press_n(K_A, 2);  chk("a_step",    1, 0, 296, 0,   0, 3'b001, 1);
    press_n(K_S, 60); chk("s_ceiling", 1, 0, 296, 224, 0, 3'b001, 1);

    take_key(1, 296, 224); take_key(2, 296, 224); take_key(3, 296, 224);
    chk("three_keys", 1, 0, 296, 224, 3, 3'b001, 3);
    obj_at(296, 224); step(); obj_at(150, 150);
    chk("door_success", 2, 0, 296, 224, 3, 3'b011, 3);
    press(K_D); chk("move_ignored", 2, 0, 296, 224, 3, 3'b011, 0);

    press(K_N); chk("next_stage", 1, 1, 8, 8, 0, 3'b011, 0);
    // Object left on the player: one pickup per 3 cycles, then the door.
    tk_q.push_back(1); tk_q.push_back(2); tk_q.push_back(3);
    obj_at(8, 8); step();
    for (int i = 0; i < 9; i++)
      chk($sformatf("hold_win%0d", i), 1, 1, 8, 8, i / 3 + 1, 3'b011, (i >= 7) ? 3 : 1);
    chk("kept_overlap_door", 2, 1, 8, 8, 3, 3'b111, 3);
    obj_at(150, 150);

    press(K_N); chk("stage_idx2", 1, 2, 8, 8, 0, 3'b111, 0);
    take_key(1, 8, 8); take_key(2, 8, 8); take_key(3, 8, 8);
    chk("stage2_keys", 1, 2, 8, 8, 3, 3'b111, 3);
    obj_at(8, 8); boss_at(8, 8); step();
    obj_at(150, 150); boss_at(250, 100);
    chk("boss_priority", 3, 2, 8, 8, 3, 3'b111, 3);
    press(K_N); chk("fail_ignores_n", 3, 2, 8, 8, 3, 3'b111, 0);
    press(K_R); chk("retry", 1, 2, 8, 8, 0, 3'b111, 0);
    boss_at(8, 8); step(); boss_at(250, 100);
    chk("boss_fail", 3, 2, 8, 8, 0, 3'b111, 1);
    press(K_B); chk("fail_to_title", 0, 2, 8, 8, 0, 3'b111, 0);

    press(4'd3); chk("title_stage3", 1, 2, 8, 8, 0, 3'b111, 0);
    take_key(1, 8, 8); take_key(2, 8, 8); take_key(3, 8, 8);
    obj_at(8, 8); step(); obj_at(150, 150);
    chk("last_success", 2, 2, 8, 8, 3, 3'b111, 3);
    press(K_N); chk("staff",        4, 2, 8, 8, 3, 3'b111, 0);
    press(K_N); chk("staff_hold",   4, 2, 8, 8, 3, 3'b111, 0);
    press(K_B); chk("staff_title",  0, 2, 8, 8, 3, 3'b111, 0);

    press(4'd2); chk("play_stage1", 1, 1, 8, 8, 0, 3'b111, 0);
    press_n(K_D, 2); take_key(1, 16, 8);
    rst = 1'b1; #1;
    chk("rst_mid_play", 0, 0, 8, 8, 0, 3'b001, 0);
    rst = 1'b0;
    press(4'd2); chk("rst_relocks", 0, 0, 8, 8, 0, 3'b001, 0);
    done = 1'b1;
  end
endmodule
